range_sequencer: RTL and testbench
==================================

RANGE_SEQUENCER -- requirements
Module: range_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter DEPTH, default 16, sample buffer entries (power of 2, at least 2).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  push load_data into buffer this cycle.
REQ-006 load_data  input  WIDTH  sample to push, unsigned.
REQ-007 start  input  1  begin streaming the buffered samples.
REQ-008 data_out  output  WIDTH  sample presented to the range-finder data input.
REQ-009 go  output  1  start-of-sequence strobe to the range finder.
REQ-010 finish  output  1  end-of-sequence strobe to the range finder.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 full  output  1  buffer holds DEPTH samples.
REQ-013 exp_range  output  WIDTH  expected range (max minus min) of the buffered samples.
REQ-014 error  output  1  one-cycle pulse on an illegal request.

Function
REQ-015 The FSM SHALL have states IDLE, GO, STREAM and FIN.
REQ-016 In IDLE, load with !full SHALL write load_data at the write pointer and increment the count.
REQ-017 In IDLE, start with count>0 SHALL enter GO on the next cycle; start has priority over a simultaneous load, which SHALL be dropped with an error pulse.
REQ-018 GO (one cycle): go=1, data_out=entry 0; then STREAM if count>1, else FIN.
REQ-019 STREAM: data_out SHALL equal entry k on the k-th cycle after GO, one sample per cycle with no gaps; after entry count-1, enter FIN.
REQ-020 FIN (one cycle): finish=1, data_out held at the last sample, go=0; then IDLE.
REQ-021 go and finish SHALL never be high in the same cycle; for count=N, go is high in cycle 0 and finish in cycle N.
REQ-022 data_out SHALL be 0 whenever the state is IDLE.
REQ-023 exp_range SHALL update the cycle after each accepted load: running max minus running min, unsigned, no wrap (max >= min always); 0 when count is 0 or 1.
REQ-024 error SHALL pulse for one cycle on: load while full; load while busy; start with count=0; start while busy. The request SHALL otherwise be ignored.
REQ-025 full SHALL equal (count==DEPTH); a load on the cycle full rises SHALL be accepted, and the next load SHALL flag an error.
REQ-026 After FIN, the buffer SHALL be cleared: count=0, exp_range=0, running max and min reset (see REQ-030).

Reset
REQ-027 When reset is high at a clock edge, the block SHALL enter IDLE with count=0 and data_out=0, go=0, finish=0, busy=0, full=0, exp_range=0, error=0.
REQ-028 Reset asserted mid-stream SHALL abort the stream with no finish pulse; the buffer contents are discarded.
REQ-029 Reset SHALL take priority over load and start in the same cycle.

Configuration
REQ-030 Macro RANGE_SEQ_REPLAY_EN: when defined, FIN SHALL return to IDLE with the buffer, count and exp_range retained, so a later start replays the same sequence. Loads append until full.
REQ-031 Without RANGE_SEQ_REPLAY_EN, REQ-026 applies and replay logic SHALL be absent.

Verification
REQ-032 Load 5,20,3,9, then start: go with data 5; then 20, 3 and 9 on consecutive cycles; finish with data 9 four cycles after go; exp_range=17.
REQ-033 Load single 42, then start: go/42 in cycle 0, finish/42 in cycle 1, exp_range=0; count=0 afterwards (macro off).
REQ-034 start with an empty buffer -> error=1 for one cycle, busy stays 0, no go pulse.
REQ-035 Load DEPTH=16 values 0..15 -> full=1, exp_range=15; a 17th load -> error pulse, count stays 16.
REQ-036 Assert reset in the STREAM cycle after go -> next cycle all outputs 0, state IDLE, no finish pulse.
REQ-037 With RANGE_SEQ_REPLAY_EN, load 7,1 and start twice -> two identical go/7, 1, finish/1 sequences; exp_range=6 throughout.

Source files
------------

// File: rtl/range_sequencer_if.sv
// Sample-loading and range-finder streaming bundle for range_sequencer.
// master = the sample source / range-finder side, slave = range_sequencer.
interface range_sequencer_if #(
    parameter int WIDTH = 8
);
    // load and start are single-cycle requests with no ready; the sequencer
    // either acts on a request in the cycle it is sampled or rejects it
    // with a one-cycle error pulse. go/finish are one-cycle strobes framing data_out.
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             full;
    logic [WIDTH-1:0] exp_range;
    logic             error;
    logic [1:0]       dbg_state;

    modport master (
        output load, load_data, start,
        input  data_out, go, finish, busy, full, exp_range, error, dbg_state
    );

    modport slave (
        input  load, load_data, start,
        output data_out, go, finish, busy, full, exp_range, error, dbg_state
    );
endinterface

// File: rtl/range_sequencer.sv
// Buffers samples, then streams them to a range finder framed by go/finish.
// Define RANGE_SEQ_REPLAY_EN to keep the buffer after a stream so start replays it.
module range_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    range_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GO     = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] ld_max;
    logic [WIDTH-1:0] ld_min;
    logic [CW-1:0]    last_idx;
    logic             at_last;

    // First accepted sample seeds both extremes so max >= min always holds.
    always_comb begin
        ld_max = run_max;
        ld_min = run_min;
        if (count == '0 || bus.load_data > run_max) ld_max = bus.load_data;
        if (count == '0 || bus.load_data < run_min) ld_min = bus.load_data;
    end

    assign last_idx      = count - 1'b1;
    assign at_last       = (CW'(rd_idx) == last_idx);
    assign bus.full      = (count == CW'(DEPTH));
    assign bus.dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            rd_idx        <= '0;
            run_max       <= '0;
            run_min       <= '0;
            bus.data_out  <= '0;
            bus.go        <= 1'b0;
            bus.finish    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.exp_range <= '0;
            bus.error     <= 1'b0;
        end else begin
            bus.error  <= 1'b0;
            bus.go     <= 1'b0;
            bus.finish <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over a simultaneous load; the load is dropped.
                    if (bus.start) begin
                        if (count == '0 || bus.load) bus.error <= 1'b1;
                        if (count != '0) begin
                            state        <= GO;
                            bus.go       <= 1'b1;
                            bus.busy     <= 1'b1;
                            bus.data_out <= mem[0];
                            rd_idx       <= '0;
                        end
                    end else if (bus.load) begin
                        if (bus.full) begin
                            bus.error <= 1'b1;
                        end else begin
                            mem[count[AW-1:0]] <= bus.load_data;
                            count              <= count + 1'b1;
                            run_max            <= ld_max;
                            run_min            <= ld_min;
                            bus.exp_range      <= ld_max - ld_min;
                        end
                    end
                end
                GO, STREAM: begin
                    if (bus.load || bus.start) bus.error <= 1'b1;
                    if (at_last) begin
                        state      <= FIN;
                        bus.finish <= 1'b1;
                    end else begin
                        state        <= STREAM;
                        rd_idx       <= rd_idx + 1'b1;
                        bus.data_out <= mem[rd_idx + 1'b1];
                    end
                end
                FIN: begin
                    if (bus.load || bus.start) bus.error <= 1'b1;
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.data_out <= '0;
`ifdef RANGE_SEQ_REPLAY_EN
                    // Buffer, count and range survive for the next start.
`else
                    count         <= '0;
                    run_max       <= '0;
                    run_min       <= '0;
                    bus.exp_range <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_range_sequencer.sv
// Directed table-driven bench for range_sequencer plus hand-written corner sequences.
module tb_range_sequencer;
    localparam int W = 8;
    localparam int D = 16;
`ifdef RANGE_SEQ_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] d;
        logic         st;
        logic [W-1:0] dout;
        logic         go;
        logic         fin;
        logic         busy;
        logic         full;
        logic [W-1:0] rng;
        logic         err;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];
    logic [W-1:0] exp_q[$];

    range_sequencer_if #(.WIDTH(W)) bus ();

    range_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic ld, input int d, input logic st,
                                input int dout, input logic go, input logic fin, input logic busy,
                                input logic full, input int rng, input logic err);
        vec_t v;
        v.rst = rst; v.ld = ld; v.d = W'(d); v.st = st;
        v.dout = W'(dout); v.go = go; v.fin = fin; v.busy = busy;
        v.full = full; v.rng = W'(rng); v.err = err;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic ld, input int d, input logic st);
        reset         = rst;
        bus.load      = ld;
        bus.load_data = W'(d);
        bus.start     = st;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int idx, input vec_t v);
        logic [2*W+4:0] got, want;
        got  = {bus.data_out, bus.go, bus.finish, bus.busy, bus.full, bus.exp_range, bus.error};
        want = {v.dout, v.go, v.fin, v.busy, v.full, v.rng, v.err};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[%0d]: got dout=%0d go=%b fin=%b busy=%b full=%b rng=%0d err=%b, want dout=%0d go=%b fin=%b busy=%b full=%b rng=%0d err=%b",
                     name, idx, bus.data_out, bus.go, bus.finish, bus.busy, bus.full, bus.exp_range,
                     bus.error, v.dout, v.go, v.fin, v.busy, v.full, v.rng, v.err);
        end
    endtask

    task automatic apply(input string name, input int idx, input vec_t v);
        drive(v.rst, v.ld, int'(v.d), v.st);
        check(name, idx, v);
    endtask

    initial begin
        reset = 1'b1;
        bus.load = 1'b0;
        bus.load_data = '0;
        bus.start = 1'b0;

        //           rst ld  d   st  dout go fin busy full rng err
        tbl.push_back(mk(1, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
`ifdef RANGE_SEQ_REPLAY_EN
        tbl.push_back(mk(0, 1, 7,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1,  0,  0, 0, 0, 0, 0,  6, 0));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(0, 0, 0, 1, 7, 1, 0, 1, 0, 6, 0));
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 6, 0));
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 6, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        end
        tbl.push_back(mk(0, 1, 30, 0,  0, 0, 0, 0, 0, 29, 0));
`else
        tbl.push_back(mk(0, 1, 5,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 20, 0,  0, 0, 0, 0, 0, 15, 0));
        tbl.push_back(mk(0, 1, 3,  0,  0, 0, 0, 0, 0, 17, 0));
        tbl.push_back(mk(0, 1, 9,  0,  0, 0, 0, 0, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  1,  5, 1, 0, 1, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  0, 20, 0, 0, 1, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  0,  3, 0, 0, 1, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  0,  9, 0, 0, 1, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  0,  9, 0, 1, 1, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        // start on an empty buffer
        tbl.push_back(mk(0, 0, 0,  1,  0, 0, 0, 0, 0,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        // single sample, then buffer must be empty again
        tbl.push_back(mk(0, 1, 42, 0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 42, 1, 0, 1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 42, 0, 1, 1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  1,  0, 0, 0, 0, 0,  0, 1));
        // load and start while busy
        tbl.push_back(mk(0, 1, 7,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 2,  0,  0, 0, 0, 0, 0,  5, 0));
        tbl.push_back(mk(0, 0, 0,  1,  7, 1, 0, 1, 0,  5, 0));
        tbl.push_back(mk(0, 1, 99, 0,  2, 0, 0, 1, 0,  5, 1));
        tbl.push_back(mk(0, 0, 0,  1,  2, 0, 1, 1, 0,  5, 1));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        // simultaneous load+start: start wins, load dropped with error
        tbl.push_back(mk(0, 1, 4,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 6,  1,  4, 1, 0, 1, 0,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0,  4, 0, 1, 1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        // reset beats load and start
        tbl.push_back(mk(0, 1, 8,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(1, 1, 9,  1,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  1,  0, 0, 0, 0, 0,  0, 1));
`endif
        for (int i = 0; i < tbl.size(); i++) apply("table", i, tbl[i]);

        // Fill to DEPTH with 0..15, overflow, then stream all 16 back.
        drive(1, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            drive(0, 1, i, 0);
            exp_q.push_back(W'(i));
            check("fill", i, mk(0, 0, 0, 0, 0, 0, 0, 0, (i == D - 1), i, 0));
        end
        apply("overflow", 0, mk(0, 1, 99, 0, 0, 0, 0, 0, 1, 15, 1));
        drive(0, 0, 0, 1);
        check("full_go", 0, mk(0, 0, 0, 0, int'(exp_q.pop_front()), 1, 0, 1, 1, 15, 0));
        for (int k = 1; k < D; k++) begin
            drive(0, 0, 0, 0);
            check("full_stream", k, mk(0, 0, 0, 0, int'(exp_q.pop_front()), 0, 0, 1, 1, 15, 0));
        end
        apply("full_fin", 0, mk(0, 0, 0, 0, 15, 0, 1, 1, 1, 15, 0));
        apply("full_idle", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, REPLAY, REPLAY ? 15 : 0, 0));

        // Reset during STREAM aborts with no finish and discards the buffer.
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 2, 0);
        drive(0, 1, 3, 0);
        apply("abort_go", 0, mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 2, 0));
        apply("abort_stream", 0, mk(0, 0, 0, 0, 2, 0, 0, 1, 0, 2, 0));
        apply("abort_rst", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        n_vec++;
        if (bus.dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL abort_state: got %0d, want 0", bus.dbg_state);
        end
        for (int k = 0; k < 3; k++) apply("abort_quiet", k, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("abort_empty", 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
